// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_pkg
// Brief    : Shared types and default address map for the memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

    // Command encoding produced by the CPU control FSM
    typedef enum logic [1:0] {
        NONE    = 2'b00,
        READ    = 2'b01,
        WRITE   = 2'b10,
        ILLEGAL = 2'b11
    } mem_cmd_t;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } bridge_state_t;

    // Address-decode result for the latched access address
    typedef enum logic [1:0] {
        RAM      = 2'b00,
        LED      = 2'b01,
        SW       = 2'b10,
        UNMAPPED = 2'b11
    } region_t;

    // Default memory-mapped I/O addresses
    localparam logic [8:0] c_led_addr = 9'h100;
    localparam logic [8:0] c_sw_addr  = 9'h140;

endpackage
`default_nettype wire

// File: rtl/mem_bridge_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_ram
// Brief    : Single-port synchronous RAM, write-enable, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge_ram #(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_W    = 8,
    parameter int    DATA_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port plus read-before-write registered read
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge
// Brief    : Memory-side bridge for the CPU control FSM. Services read/write
//            commands from on-chip RAM or switch/LED registers after a
//            programmable number of wait states; returns read data with a
//            one-cycle ready strobe and flags unmapped/illegal accesses.
// Config   : MEM_BRIDGE_SYNC_SW_EN - two-flop synchronizer on the switches.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int                ADDR_W        = 9,
    parameter int                DATA_W        = 16,
    parameter int                RAM_DEPTH     = 256,
    parameter int                WAIT_CYCLES   = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR      = c_led_addr,
    parameter logic [ADDR_W-1:0] SW_ADDR       = c_sw_addr,
    parameter string             RAM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [7:0]        sw,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic [7:0]        led,
    output logic              err
);

    localparam int         c_ram_aw    = $clog2(RAM_DEPTH);
    // First WAIT cycle is the accept edge itself, hence the minus one
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    bridge_state_t     r_state;
    logic [3:0]        r_cnt;
    mem_cmd_t          r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_read_data;
    logic              r_ready;
    logic              r_err;
    logic [7:0]        r_led;

    region_t             w_region;
    logic                w_ram_we;
    logic [c_ram_aw-1:0] w_ram_addr;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic [7:0]          w_sw;

`ifdef MEM_BRIDGE_SYNC_SW_EN
    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_sync;

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw = r_sw_sync;
`else
    assign w_sw = sw;
`endif

    // Decode the latched address; RAM takes priority over I/O addresses
    always_comb begin
        w_region = UNMAPPED;
        if (32'(r_addr) < RAM_DEPTH) begin
            w_region = RAM;
        end else if (r_addr == LED_ADDR) begin
            w_region = LED;
        end else if (r_addr == SW_ADDR) begin
            w_region = SW;
        end
    end

    // The RAM reads the incoming address on the accept edge so that its
    // registered output is already valid when DONE is reached, even with
    // zero wait states.
    assign w_ram_addr = (r_state == IDLE) ? mem_addr[c_ram_aw-1:0] : r_addr[c_ram_aw-1:0];
    assign w_ram_we   = (r_state == DONE) && (r_cmd == WRITE) && (w_region == RAM);

    mem_bridge_ram #(
        .DEPTH     (RAM_DEPTH),
        .ADDR_W    (c_ram_aw),
        .DATA_W    (DATA_W),
        .INIT_FILE (RAM_INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // Access sequencer: accept, count wait states, complete with strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_cmd       <= NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_led       <= 8'h00;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_cmd != 2'b00) begin
                        r_cmd   <= mem_cmd_t'(mem_cmd);
                        r_addr  <= mem_addr;
                        r_wdata <= write_data;
                        r_cnt   <= c_wait_load;
                        r_state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                    case (r_cmd)
                        READ: begin
                            case (w_region)
                                RAM:     r_read_data <= w_ram_rdata;
                                LED:     r_read_data <= {{(DATA_W-8){1'b0}}, r_led};
                                SW:      r_read_data <= {{(DATA_W-8){1'b0}}, w_sw};
                                default: r_err       <= 1'b1;
                            endcase
                        end
                        WRITE: begin
                            case (w_region)
                                RAM:     ; // performed by the RAM write enable
                                LED:     r_led <= r_wdata[7:0];
                                default: r_err <= 1'b1;
                            endcase
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_data = r_read_data;
    assign mem_ready = r_ready;
    assign led       = r_led;
    assign err       = r_err;

endmodule
`default_nettype wire
